// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch with a 2-entry queue, credit flow control and
//               redirect flush that drops stale in-flight responses.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] c_nop   = 32'h0000_0013;
    localparam logic [2:0]  c_depth = 3'(QDEPTH);

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [1:0]  r_count;
    logic [1:0]  r_outstanding;
    logic [1:0]  r_discard;
    logic [31:0] r_ra0, r_ra1;
    logic [31:0] r_q0_instr, r_q0_pc, r_q0_pc4;
    logic [31:0] r_q1_instr, r_q1_pc, r_q1_pc4;

    logic        w_pop, w_resp, w_drop, w_push, w_accept;
    logic [2:0]  w_occ;
    logic [1:0]  w_out_next, w_track_level, w_discard_next, w_discard_redir;
    logic [31:0] w_push_pc4;
    logic        w_unused_bits;

    assign id_valid   = (r_count != 2'd0);
    assign id_instr   = r_q0_instr;
    assign id_pc      = r_q0_pc;
    assign id_pc4     = r_q0_pc4;

    assign w_pop      = id_valid && id_ready;
    // Responses with nothing outstanding belong to requests abandoned by reset.
    assign w_resp     = imem_resp_valid && (r_outstanding != 2'd0);
    assign w_drop     = w_resp && (r_discard != 2'd0);
    assign w_push     = w_resp && !w_drop;

    // Occupancy counts stale requests too; a pop this cycle frees its slot.
    assign w_occ          = {1'b0, r_count} + {1'b0, r_outstanding} - {2'b00, w_pop};
    assign imem_req_valid = (r_state != ST_BOOT) && !redirect_valid && (w_occ < c_depth);
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_track_level   = r_outstanding - {1'b0, w_resp};
    assign w_out_next      = w_track_level + {1'b0, w_accept};
    assign w_discard_redir = w_track_level;
    assign w_discard_next  = r_discard - {1'b0, w_drop};
    assign w_push_pc4      = r_ra0 + 32'd4;
    assign w_unused_bits   = &{1'b0, redirect_pc[1:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_BOOT;
            r_fetch_pc    <= RESET_PC;
            r_count       <= 2'd0;
            r_outstanding <= 2'd0;
            r_discard     <= 2'd0;
            r_ra0         <= '0;
            r_ra1         <= '0;
            r_q0_instr    <= c_nop;
            r_q0_pc       <= '0;
            r_q0_pc4      <= '0;
            r_q1_instr    <= c_nop;
            r_q1_pc       <= '0;
            r_q1_pc4      <= '0;
        end else begin
            // Request-address tracker mirrors the memory and ignores redirects.
            r_outstanding <= w_out_next;
            if (w_resp) begin
                r_ra0 <= r_ra1;
            end
            if (w_accept) begin
                if (w_track_level == 2'd0) begin
                    r_ra0 <= r_fetch_pc;
                end else begin
                    r_ra1 <= r_fetch_pc;
                end
            end

            if (redirect_valid) begin
                r_count    <= 2'd0;
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
                r_discard  <= w_discard_redir;
                r_state    <= (w_discard_redir != 2'd0) ? ST_DRAIN : ST_RUN;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                r_discard <= w_discard_next;

                case ({w_push, w_pop})
                    2'b10: begin
                        if (r_count == 2'd0) begin
                            r_q0_instr <= imem_resp_data;
                            r_q0_pc    <= r_ra0;
                            r_q0_pc4   <= w_push_pc4;
                        end else begin
                            r_q1_instr <= imem_resp_data;
                            r_q1_pc    <= r_ra0;
                            r_q1_pc4   <= w_push_pc4;
                        end
                        r_count <= r_count + 2'd1;
                    end
                    2'b01: begin
                        r_q0_instr <= r_q1_instr;
                        r_q0_pc    <= r_q1_pc;
                        r_q0_pc4   <= r_q1_pc4;
                        r_count    <= r_count - 2'd1;
                    end
                    2'b11: begin
                        if (r_count == 2'd1) begin
                            r_q0_instr <= imem_resp_data;
                            r_q0_pc    <= r_ra0;
                            r_q0_pc4   <= w_push_pc4;
                        end else begin
                            r_q0_instr <= r_q1_instr;
                            r_q0_pc    <= r_q1_pc;
                            r_q0_pc4   <= r_q1_pc4;
                            r_q1_instr <= imem_resp_data;
                            r_q1_pc    <= r_ra0;
                            r_q1_pc4   <= w_push_pc4;
                        end
                    end
                    default: ;
                endcase

                case (r_state)
                    ST_BOOT:  r_state <= ST_RUN;
                    ST_DRAIN: r_state <= (w_discard_next == 2'd0) ? ST_RUN : ST_DRAIN;
                    default:  r_state <= ST_RUN;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Randomized bench for fetch_unit against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc, id_pc4;

    fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(2)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4)
    );

    always #5 clk = ~clk;

    // Memory holds requests in order; gen tags which redirect epoch issued them.
    typedef struct {
        logic [31:0] addr;
        int          gen;
        int          due;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] iq[$];
    int          checks = 0, errors = 0, cyc = 0, gen = 0, pops = 0, accepts = 0;
    int          p_idr = 100, p_reqr = 100, p_resp = 100, lat = 1;
    bit          bogus = 1'b0;
    logic [31:0] exp_fetch = RESET_PC;
    bit          hold_pending = 1'b0;
    logic [31:0] hold_addr = '0;
    logic        s_req_valid, s_id_valid, s_resp;
    logic [31:0] s_req_addr, s_id_pc, s_id_pc4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit redir, input logic [31:0] rpc);
        bit          pop, acc, resp, push;
        logic [31:0] paddr;
        mreq_t       e, n;
        push  = 1'b0;
        paddr = '0;
        redirect_valid = redir;
        redirect_pc    = rpc;
        id_ready       = ($urandom_range(99) < p_idr);
        imem_req_ready = ($urandom_range(99) < p_reqr);
        resp = 1'b0;
        if (memq.size() != 0) begin
            if (cyc >= memq[0].due && $urandom_range(99) < p_resp) resp = 1'b1;
        end else if (bogus) begin
            resp = 1'b1;
        end
        imem_resp_valid = resp;
        imem_resp_data  = (resp && memq.size() != 0) ? mem_word(memq[0].addr) : $urandom;
        #1;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_id_valid  = id_valid;
        s_id_pc     = id_pc;
        s_id_pc4    = id_pc4;
        s_resp      = resp;
        pop = (iq.size() != 0) && id_ready && !redir;
        acc = imem_req_valid && imem_req_ready;

        chk("id_valid", 32'(id_valid), 32'(iq.size() != 0));
        if (iq.size() != 0) begin
            chk("id_pc", id_pc, iq[0]);
            chk("id_instr", id_instr, mem_word(iq[0]));
            chk("id_pc4", id_pc4, iq[0] + 32'd4);
        end
        if (redir) begin
            chk("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
        end else begin
            if (hold_pending) begin
                chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
                chk("req_hold_addr", imem_req_addr, hold_addr);
            end
            if (iq.size() + memq.size() >= 2 && !pop)
                chk("credit_block", 32'(imem_req_valid), 32'd0);
        end
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch);

        if (resp && memq.size() != 0) begin
            e     = memq.pop_front();
            push  = !redir && (e.gen == gen);
            paddr = e.addr;
        end
        if (acc) begin
            n.addr = imem_req_addr;
            n.gen  = gen;
            n.due  = cyc + lat;
            memq.push_back(n);
            accepts++;
            chk("outstanding_bound", 32'(memq.size() <= 2), 32'd1);
        end
        if (redir) begin
            iq.delete();
            gen++;
            exp_fetch    = {rpc[31:2], 2'b00};
            hold_pending = 1'b0;
        end else begin
            if (pop) begin
                void'(iq.pop_front());
                pops++;
            end
            if (push) begin
                chk("queue_room", 32'(iq.size() < 2), 32'd1);
                iq.push_back(paddr);
            end
            if (acc) exp_fetch = exp_fetch + 32'd4;
            hold_pending = imem_req_valid && !imem_req_ready;
            hold_addr    = imem_req_addr;
        end
        bogus = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    // Reset applied mid-cycle; stray responses keep arriving while it is held.
    task automatic do_reset(input bit stray);
        rstn            = 1'b0;
        redirect_valid  = 1'b0;
        id_ready        = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = stray;
        imem_resp_data  = $urandom;
        #2;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_instr", id_instr, 32'h0000_0013);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_pc4", id_pc4, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        iq.delete();
        memq.delete();
        gen++;
        exp_fetch    = RESET_PC;
        hold_pending = 1'b0;
    endtask

    task automatic wait_id(input string tag, input int budget);
        int k;
        k = 0;
        step(1'b0, '0);
        while (!s_id_valid && k < budget) begin
            step(1'b0, '0);
            k++;
        end
        chk({tag, "_seen"}, 32'(s_id_valid), 32'd1);
    endtask

    initial begin
        int p0, a0;
        rstn = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        @(negedge clk);

        // Sustained streaming from reset with single-cycle memory.
        do_reset(1'b0);
        step(1'b0, '0);
        chk("boot_no_req", 32'(s_req_valid), 32'd0);
        step(1'b0, '0);
        chk("req0_addr", s_req_valid ? s_req_addr : 32'hDEAD_0000, 32'h0000_3000);
        step(1'b0, '0);
        chk("req1_addr", s_req_valid ? s_req_addr : 32'hDEAD_0000, 32'h0000_3004);
        step(1'b0, '0);
        chk("req2_addr", s_req_valid ? s_req_addr : 32'hDEAD_0000, 32'h0000_3008);
        chk("first_id_pc", s_id_pc, 32'h0000_3000);
        p0 = pops;
        repeat (16) step(1'b0, '0);
        chk("throughput", 32'(pops - p0), 32'd16);

        // Decode stall fills the queue, then drains in order at full rate.
        p_idr = 0;
        a0 = accepts;
        repeat (10) step(1'b0, '0);
        chk("stall_req_count", 32'(accepts - a0 <= 2), 32'd1);
        chk("stall_id_valid", 32'(s_id_valid), 32'd1);
        chk("stall_req_low", 32'(s_req_valid), 32'd0);
        p_idr = 100;
        p0 = pops;
        repeat (10) step(1'b0, '0);
        chk("drain_pops", 32'(pops - p0), 32'd10);

        // Redirect colliding with a response and a pop.
        step(1'b1, 32'h0000_3102);
        chk("collide_resp", 32'(s_resp), 32'd1);
        chk("collide_id_valid", 32'(s_id_valid), 32'd1);
        step(1'b0, '0);
        chk("collide_id_flushed", 32'(s_id_valid), 32'd0);
        chk("collide_req_addr", s_req_valid ? s_req_addr : 32'hDEAD_0000, 32'h0000_3100);
        repeat (6) step(1'b0, '0);

        // Redirect to the top of the address space wraps.
        step(1'b1, 32'hFFFF_FFFC);
        wait_id("wrap", 20);
        chk("wrap_id_pc", s_id_pc, 32'hFFFF_FFFC);
        chk("wrap_id_pc4", s_id_pc4, 32'h0000_0000);
        step(1'b0, '0);
        chk("wrap_next_pc", s_id_pc, 32'h0000_0000);

        // Two stale requests in flight at redirect.
        do_reset(1'b0);
        lat = 3;
        repeat (3) step(1'b0, '0);
        step(1'b1, 32'h0000_3100);
        step(1'b0, '0);
        chk("drain_state", 32'(dut.r_state), 32'd2);
        wait_id("stale", 20);
        chk("stale_id_pc", s_id_pc, 32'h0000_3100);
        chk("run_state", 32'(dut.r_state), 32'd1);

        // Memory back-pressure holds the first request.
        do_reset(1'b0);
        lat = 1;
        p_reqr = 0;
        step(1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0);
            chk("bp_valid", 32'(s_req_valid), 32'd1);
            chk("bp_addr", s_req_addr, 32'h0000_3000);
        end
        p_reqr = 100;
        step(1'b0, '0);
        step(1'b0, '0);
        chk("bp_next_addr", s_req_addr, 32'h0000_3004);

        // Reset in the middle of traffic with stray responses around it.
        lat = 2;
        repeat (20) step(1'b0, '0);
        do_reset(1'b1);
        bogus = 1'b1;
        step(1'b0, '0);
        chk("post_rst_id_valid", 32'(s_id_valid), 32'd0);
        chk("post_rst_boot", 32'(s_req_valid), 32'd0);
        repeat (10) step(1'b0, '0);

        // Randomized traffic with sporadic redirects.
        for (int seg = 0; seg < 6; seg++) begin
            p_idr  = int'($urandom_range(100, 30));
            p_reqr = int'($urandom_range(100, 30));
            p_resp = int'($urandom_range(100, 40));
            lat    = int'($urandom_range(3, 1));
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(99) < 4) step(1'b1, $urandom);
                else step(1'b0, '0);
            end
        end

        // Back-to-back redirects: the later target wins.
        p_idr = 100; p_reqr = 100; p_resp = 100; lat = 1;
        step(1'b1, 32'h0000_4000);
        step(1'b1, 32'h0000_5007);
        wait_id("b2b", 30);
        chk("b2b_id_pc", s_id_pc, 32'h0000_5004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
